// File: rtl/bexkat1_pkg.sv
// ============================================================================
// Module   : bexkat1_pkg
// Purpose  : Shared writeback request type and scheduler defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bexkat1_pkg;

    localparam int                   WB_WIDTH           = 32;
    localparam int                   WB_COUNTP          = 4;
    localparam logic [WB_COUNTP-1:0] DEFAULT_SPREG      = 4'd15;
    localparam int                   DEFAULT_STARVE_MAX = 3;

    typedef struct packed {
        logic [WB_COUNTP-1:0] addr;
        logic [WB_WIDTH-1:0]  data;
        logic [1:0]           be;
    } wb_req_t;

    // An all-zero enable on a live request means a full-word write.
    function automatic logic [1:0] wb_be_norm(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_priority_arb.sv
// ============================================================================
// Module   : wb_priority_arb
// Purpose  : Two-requester fixed-priority arbiter with optional starvation override.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_priority_arb
    import bexkat1_pkg::*;
#(
    parameter bit STARVE_EN  = 1'b1,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hi_valid,
    input  logic hi_block,
    input  logic lo_valid,
    input  logic lo_block,
    output logic hi_grant,
    output logic lo_grant
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          hi_elig;
    logic          lo_elig;
    logic          force_lo;

    assign hi_elig  = hi_valid && !hi_block;
    assign lo_elig  = lo_valid && !lo_block;
    assign force_lo = STARVE_EN && (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        hi_grant = 1'b0;
        lo_grant = 1'b0;
        if (!rst_i) begin
            if (lo_elig && (force_lo || !hi_elig)) begin
                lo_grant = 1'b1;
            end else if (hi_elig) begin
                hi_grant = 1'b1;
            end
        end
    end

    // Counts raw lo_valid denials, including cycles where lo was blocked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (!STARVE_EN || !lo_valid || lo_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Arbitrates register file write ports and tracks pending writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_scheduler
    import bexkat1_pkg::*;
#(
    parameter int                WIDTH      = WB_WIDTH,
    parameter int                COUNTP     = WB_COUNTP,
    parameter logic [COUNTP-1:0] SPREG      = DEFAULT_SPREG,
    parameter int                STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              supervisor,
    input  logic              flush_i,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [COUNTP-1:0] alu_addr,
    input  logic [WIDTH-1:0]  alu_data,
    input  logic [1:0]        alu_be,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [COUNTP-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    input  logic [1:0]        mem_be,
    input  logic              msp_valid,
    output logic              msp_ready,
    input  logic [WIDTH-1:0]  msp_data,
    input  logic [1:0]        msp_be,
    input  logic              exc_valid,
    output logic              exc_ready,
    input  logic [WIDTH-1:0]  exc_data,
    input  logic              rsv_en,
    input  logic [COUNTP-1:0] rsv_addr,
    input  logic              rd1_use,
    input  logic [COUNTP-1:0] rd1_addr,
    input  logic              rd2_use,
    input  logic [COUNTP-1:0] rd2_addr,
    output logic [COUNTP-1:0] write_addr,
    output logic [WIDTH-1:0]  write_data,
    output logic [1:0]        write_en,
    output logic [WIDTH-1:0]  sp_data_i,
    output logic [1:0]        sp_en,
    output logic              stall_o
);

    localparam int COUNT = 2 ** COUNTP;

    wb_req_t          alu_req, mem_req, gen_req;
    logic             alu_grant, mem_grant, exc_grant, msp_grant;
    logic             gen_grant, sp_grant;
    logic [COUNT-1:0] pending, set_vec, clr_vec, pend_eff;
    logic             pending_ssp, set_ssp, clr_ssp, ssp_eff;
    logic             sup_prev;
    logic             rd1_hit, rd2_hit, rsv_hit, mode_hit;

    function automatic logic busy(input logic [COUNTP-1:0] a, input logic sup,
                                  input logic [COUNT-1:0] pv, input logic sv);
        return (sup && a == SPREG) ? sv : pv[a];
    endfunction

    assign alu_req.addr = alu_addr;
    assign alu_req.data = alu_data;
    assign alu_req.be   = alu_be;
    assign mem_req.addr = mem_addr;
    assign mem_req.data = mem_data;
    assign mem_req.be   = mem_be;

    assign sp_grant  = exc_grant || msp_grant;
    assign gen_grant = alu_grant || mem_grant;

    wb_priority_arb #(.STARVE_EN(1'b0), .STARVE_MAX(1)) u_sp_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hi_valid (exc_valid),
        .hi_block (1'b0),
        .lo_valid (msp_valid),
        .lo_block (1'b0),
        .hi_grant (exc_grant),
        .lo_grant (msp_grant)
    );

    // A general write to SPREG would collide with the SP port in the register file.
    wb_priority_arb #(.STARVE_EN(1'b1), .STARVE_MAX(STARVE_MAX)) u_gen_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hi_valid (mem_valid),
        .hi_block (sp_grant && mem_addr == SPREG),
        .lo_valid (alu_valid),
        .lo_block (sp_grant && alu_addr == SPREG),
        .hi_grant (mem_grant),
        .lo_grant (alu_grant)
    );

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;
    assign exc_ready = exc_grant;
    assign msp_ready = msp_grant;

    always_comb begin
        gen_req = '0;
        if (mem_grant) begin
            gen_req = mem_req;
        end else if (alu_grant) begin
            gen_req = alu_req;
        end
    end

    assign write_addr = gen_req.addr;
    assign write_data = gen_req.data;
    assign write_en   = gen_grant ? wb_be_norm(gen_req.be) : 2'b00;
    assign sp_data_i  = exc_grant ? exc_data : (msp_grant ? msp_data : '0);
    assign sp_en      = exc_grant ? 2'b11 : (msp_grant ? wb_be_norm(msp_be) : 2'b00);

    always_comb begin
        clr_vec = '0;
        clr_ssp = 1'b0;
        if (gen_grant) begin
            if (supervisor && gen_req.addr == SPREG) begin
                clr_ssp = 1'b1;
            end else begin
                clr_vec[gen_req.addr] = 1'b1;
            end
        end
        if (sp_grant) begin
            if (supervisor) begin
                clr_ssp = 1'b1;
            end else begin
                clr_vec[SPREG] = 1'b1;
            end
        end
    end

    // Committing registers are forwarded by the register file, so they do not stall.
    assign pend_eff = pending & ~clr_vec;
    assign ssp_eff  = pending_ssp && !clr_ssp;
    assign rd1_hit  = rd1_use && busy(rd1_addr, supervisor, pend_eff, ssp_eff);
    assign rd2_hit  = rd2_use && busy(rd2_addr, supervisor, pend_eff, ssp_eff);
    assign rsv_hit  = rsv_en && busy(rsv_addr, supervisor, pend_eff, ssp_eff);
    assign mode_hit = (supervisor != sup_prev) && (pending[SPREG] || pending_ssp);
    assign stall_o  = !rst_i && (rd1_hit || rd2_hit || rsv_hit || mode_hit);

    always_comb begin
        set_vec = '0;
        set_ssp = 1'b0;
        if (rsv_en && !stall_o) begin
            if (supervisor && rsv_addr == SPREG) begin
                set_ssp = 1'b1;
            end else begin
                set_vec[rsv_addr] = 1'b1;
            end
        end
    end

    // sup_prev only follows the mode once issue is free, so a blocked mode
    // switch keeps stalling until the stack pointer writes drain or flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending     <= '0;
            pending_ssp <= 1'b0;
            sup_prev    <= 1'b0;
        end else begin
            if (flush_i) begin
                pending     <= '0;
                pending_ssp <= 1'b0;
            end else begin
                pending     <= (pending & ~clr_vec) | set_vec;
                pending_ssp <= (pending_ssp && !clr_ssp) || set_ssp;
            end
            if (!stall_o) begin
                sup_prev <= supervisor;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Self-checking bench with write-port scoreboards for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        supervisor, flush_i;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic        msp_valid, msp_ready, exc_valid, exc_ready;
    logic [3:0]  alu_addr, mem_addr, rsv_addr, rd1_addr, rd2_addr, write_addr;
    logic [31:0] alu_data, mem_data, msp_data, exc_data, write_data, sp_data_i;
    logic [1:0]  alu_be, mem_be, msp_be, write_en, sp_en;
    logic        rsv_en, rd1_use, rd2_use, stall_o;

    int checks = 0;
    int errors = 0;

    logic [37:0] gen_q[$];
    logic [33:0] sp_q[$];

    always #5 clk_i = ~clk_i;

    regfile_wb_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .supervisor(supervisor), .flush_i(flush_i),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_data(alu_data), .alu_be(alu_be),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_be(mem_be),
        .msp_valid(msp_valid), .msp_ready(msp_ready), .msp_data(msp_data), .msp_be(msp_be),
        .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_data(exc_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd1_use(rd1_use), .rd1_addr(rd1_addr), .rd2_use(rd2_use), .rd2_addr(rd2_addr),
        .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
        .sp_data_i(sp_data_i), .sp_en(sp_en), .stall_o(stall_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every committed write against the queued expectation.
    always @(negedge clk_i) begin
        logic [37:0] ge;
        logic [33:0] se;
        if (!rst_i) begin
            if (write_en != 2'b00) begin
                if (gen_q.size() == 0) begin
                    check_val("gen_unexpected", {write_addr, write_data, write_en}, 64'd0);
                end else begin
                    ge = gen_q.pop_front();
                    check_val("gen_write", {write_addr, write_data, write_en}, ge);
                end
            end
            if (sp_en != 2'b00) begin
                if (sp_q.size() == 0) begin
                    check_val("sp_unexpected", {sp_data_i, sp_en}, 64'd0);
                end else begin
                    se = sp_q.pop_front();
                    check_val("sp_write", {sp_data_i, sp_en}, se);
                end
            end
        end
    end

    task automatic idle();
        supervisor = 1'b0; flush_i = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0; alu_be = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0; mem_be = '0;
        msp_valid = 1'b0; msp_data = '0; msp_be = '0;
        exc_valid = 1'b0; exc_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rd1_use = 1'b0; rd1_addr = '0; rd2_use = 1'b0; rd2_addr = '0;
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        int scnt;
        int mcnt;
        logic [31:0] ad;
        logic        alu_wins;

        idle();
        rst_i = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1; exc_valid = 1'b1; rd1_use = 1'b1;
        #2;
        check_val("rst_alu_ready", alu_ready, 0);
        check_val("rst_mem_ready", mem_ready, 0);
        check_val("rst_exc_ready", exc_ready, 0);
        check_val("rst_write_en", write_en, 0);
        check_val("rst_sp_en", sp_en, 0);
        check_val("rst_stall", stall_o, 0);
        idle();
        adv(); adv();
        rst_i = 1'b0;

        // Reset asserted mid-cycle with a pending register
        rsv_en = 1'b1; rsv_addr = 4'd3;
        step();
        check_val("t1_rsv_stall", stall_o, 0);
        adv();
        rsv_en = 1'b0; rd1_use = 1'b1; rd1_addr = 4'd3;
        step();
        check_val("t1_pre_stall", stall_o, 1);
        #1 rst_i = 1'b1;
        #1;
        check_val("t1_async_stall", stall_o, 0);
        check_val("t1_async_pending", dut.pending, 0);
        adv(); #2;
        rst_i = 1'b0;
        step();
        check_val("t1_post_stall", stall_o, 0);
        adv();
        idle();

        // Collision: MEM first, then ALU
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h11; alu_be = 2'b00;
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'h22; mem_be = 2'b01;
        gen_q.push_back({4'd5, 32'h22, 2'b01});
        gen_q.push_back({4'd2, 32'h11, 2'b11});
        step();
        check_val("t2_c1_alu_ready", alu_ready, 0);
        check_val("t2_c1_mem_ready", mem_ready, 1);
        adv();
        mem_valid = 1'b0;
        step();
        check_val("t2_c2_alu_ready", alu_ready, 1);
        adv();
        idle();

        // Starvation: MEM held, ALU forced through after STARVE_MAX denials
        scnt = 0;
        ad = 32'hA0;
        alu_valid = 1'b1; alu_addr = 4'd4; alu_data = ad; alu_be = 2'b10;
        mem_valid = 1'b1; mem_addr = 4'd1; mem_be = 2'b11;
        for (int i = 0; i < 6; i++) begin
            mem_data = 32'h100 + i;
            alu_wins = (scnt == 3);
            if (alu_wins) begin
                gen_q.push_back({4'd4, ad, 2'b10});
                scnt = 0;
            end else begin
                gen_q.push_back({4'd1, mem_data, 2'b11});
                scnt = (scnt < 3) ? scnt + 1 : 3;
            end
            step();
            check_val($sformatf("t3_alu_ready_%0d", i), alu_ready, alu_wins);
            check_val($sformatf("t3_mem_ready_%0d", i), mem_ready, !alu_wins);
            adv();
            if (alu_wins) begin
                ad = ad + 1;
                alu_data = ad;
            end
        end
        mem_valid = 1'b0;
        gen_q.push_back({4'd4, ad, 2'b10});
        step();
        check_val("t3_alu_tail", alu_ready, 1);
        adv();
        idle();

        // Hazards: RAW on both read ports, WAW, and commit forwarding
        rsv_en = 1'b1; rsv_addr = 4'd7;
        step();
        check_val("t4_rsv_ok", stall_o, 0);
        adv();
        rsv_en = 1'b0; rd1_use = 1'b1; rd1_addr = 4'd7;
        step();
        check_val("t4_rd1_raw", stall_o, 1);
        adv();
        rd1_use = 1'b0; rd2_use = 1'b1; rd2_addr = 4'd7;
        rsv_en = 1'b1; rsv_addr = 4'd9;
        step();
        check_val("t4_rd2_raw", stall_o, 1);
        adv();
        rd2_use = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd7;
        step();
        check_val("t4_waw", stall_o, 1);
        adv();
        rsv_en = 1'b0; rd1_use = 1'b1; rd1_addr = 4'd9;
        step();
        check_val("t4_stalled_rsv_dropped", stall_o, 0);
        adv();
        rd1_addr = 4'd7;
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h77; alu_be = 2'b11;
        gen_q.push_back({4'd7, 32'h77, 2'b11});
        step();
        check_val("t4_fwd_stall", stall_o, 0);
        check_val("t4_fwd_ready", alu_ready, 1);
        adv();
        alu_valid = 1'b0;
        step();
        check_val("t4_cleared", stall_o, 0);
        adv();
        idle();

        // SP conflict: EXC owns the SP port, MEM to SPREG waits one cycle
        exc_valid = 1'b1; exc_data = 32'hE0;
        mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 32'h55; mem_be = 2'b10;
        sp_q.push_back({32'hE0, 2'b11});
        gen_q.push_back({4'd15, 32'h55, 2'b10});
        step();
        check_val("t5_exc_ready", exc_ready, 1);
        check_val("t5_mem_blocked", mem_ready, 0);
        adv();
        exc_valid = 1'b0;
        step();
        check_val("t5_mem_late", mem_ready, 1);
        adv();
        mem_valid = 1'b0;
        exc_valid = 1'b1; exc_data = 32'hE1;
        msp_valid = 1'b1; msp_data = 32'h5C; msp_be = 2'b00;
        sp_q.push_back({32'hE1, 2'b11});
        sp_q.push_back({32'h5C, 2'b11});
        step();
        check_val("t5_msp_wait", msp_ready, 0);
        adv();
        exc_valid = 1'b0;
        step();
        check_val("t5_msp_go", msp_ready, 1);
        adv();
        idle();

        // Mode: ssp reservation blocks a supervisor switch until flushed
        supervisor = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd15;
        step();
        check_val("t6_rsv_ssp", stall_o, 0);
        adv();
        rsv_en = 1'b0; rd1_use = 1'b1; rd1_addr = 4'd15;
        step();
        check_val("t6_ssp_raw", stall_o, 1);
        adv();
        rd1_use = 1'b0; supervisor = 1'b0;
        step();
        check_val("t6_mode_stall", stall_o, 1);
        adv();
        flush_i = 1'b1;
        step();
        check_val("t6_mode_hold", stall_o, 1);
        adv();
        flush_i = 1'b0;
        step();
        check_val("t6_flushed", stall_o, 0);
        adv();
        idle();

        adv(); adv();
        check_val("gen_q_drained", gen_q.size(), 0);
        check_val("sp_q_drained", sp_q.size(), 0);
        mcnt = checks;
        $display("Simulation finished: %0d checks, %0d errors", mcnt, errors);
        $finish;
    end

endmodule

`default_nettype wire
